// File: rtl/polarity_time_surface.sv
// polarity_time_surface: per-channel timestamp planes with a decayed-surface frame scanner.
// Events write asynchronously to scans; a 3-stage pipeline streams one frame over valid/ready.
`default_nettype none

module polarity_time_surface #(
  parameter int GRID_SIZE  = 16,
  parameter int NUM_CH     = 2,
  parameter int TS_BITS    = 16,
  parameter int VALUE_BITS = 8,
  parameter int MAX_VALUE  = 255,
  parameter int SHIFT_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TS_BITS-1:0]            t_now,
  input  logic                          ev_valid,
  input  logic [$clog2(NUM_CH)-1:0]     ev_ch,
  input  logic [$clog2(GRID_SIZE)-1:0]  ev_x,
  input  logic [$clog2(GRID_SIZE)-1:0]  ev_y,
  input  logic [TS_BITS-1:0]            ev_ts,
  input  logic                          cfg_mode,
  input  logic [SHIFT_BITS-1:0]         cfg_shift,
  input  logic                          scan_start,
  input  logic                          scan_clear,
  output logic                          scan_busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VALUE_BITS-1:0]         out_value,
  output logic [$clog2(NUM_CH)-1:0]     out_ch,
  output logic [$clog2(GRID_SIZE)-1:0]  out_x,
  output logic [$clog2(GRID_SIZE)-1:0]  out_y,
  output logic                          out_last,
  output logic                          frame_done
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int XY_W  = $clog2(GRID_SIZE);
  localparam int CELLS = NUM_CH * GRID_SIZE * GRID_SIZE;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [VALUE_BITS-1:0] VMAX     = VALUE_BITS'(MAX_VALUE);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TS_BITS-1:0]      t_snap_q;
  logic                    mode_q, clear_q;
  logic [SHIFT_BITS-1:0]   shift_q;
  logic                    frame_done_q;

  logic [TS_BITS-1:0]      ts_mem [CELLS];
  logic [CELLS-1:0]        valid_q;

  logic                    s0_v_q, s0_vld_q;
  logic [IDX_W-1:0]        s0_idx_q;
  logic [TS_BITS-1:0]      s0_ts_q;
  logic                    s1_v_q, s1_vld_q;
  logic [IDX_W-1:0]        s1_idx_q;
  logic [TS_BITS-1:0]      s1_steps_q;
  logic                    out_valid_q, out_last_q;
  logic [VALUE_BITS-1:0]   out_value_q;
  logic [IDX_W-1:0]        out_idx_q;

  logic                    adv, issue, hs_last;
  logic [IDX_W-1:0]        ev_addr;
  logic [TS_BITS-1:0]      delta;
  logic [VALUE_BITS-1:0]   value_d;

  assign ev_addr = {ev_ch, ev_y, ev_x};
  assign adv     = !out_valid_q || out_ready;
  assign issue   = (state_q == ST_RUN) && adv;
  assign hs_last = out_valid_q && out_ready && out_last_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (adv) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hs_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      t_snap_q     <= '0;
      mode_q       <= 1'b0;
      shift_q      <= '0;
      clear_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= hs_last;
      if (state_q == ST_IDLE && scan_start) begin
        t_snap_q <= t_now;
        mode_q   <= cfg_mode;
        shift_q  <= cfg_shift;
        clear_q  <= scan_clear;
      end
    end
  end

  // Timestamp RAM: the registered read sees the pre-write contents on a same-cell collision.
  always_ff @(posedge clk) begin
    if (ev_valid) ts_mem[ev_addr] <= ev_ts;
    if (issue)    s0_ts_q <= ts_mem[idx_q];
  end

  // Event set is applied after the clear so a colliding event keeps the cell valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (issue && clear_q) valid_q[idx_q] <= 1'b0;
      if (ev_valid)         valid_q[ev_addr] <= 1'b1;
    end
  end

  assign delta = t_snap_q - s0_ts_q;

  always_comb begin
    value_d = '0;
    if (s1_vld_q) begin
      if (!mode_q) begin
        if (s1_steps_q < TS_BITS'(VALUE_BITS)) value_d = VMAX >> s1_steps_q;
      end else begin
        if (s1_steps_q < TS_BITS'(MAX_VALUE)) value_d = VMAX - s1_steps_q[VALUE_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v_q      <= 1'b0;
      s0_vld_q    <= 1'b0;
      s0_idx_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_steps_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_value_q <= '0;
      out_idx_q   <= '0;
    end else if (adv) begin
      s0_v_q <= issue;
      if (issue) begin
        s0_vld_q <= valid_q[idx_q];
        s0_idx_q <= idx_q;
      end
      s1_v_q      <= s0_v_q;
      s1_vld_q    <= s0_vld_q;
      s1_idx_q    <= s0_idx_q;
      s1_steps_q  <= delta >> shift_q;
      out_valid_q <= s1_v_q;
      out_last_q  <= s1_v_q && (s1_idx_q == LAST_IDX);
      out_value_q <= value_d;
      out_idx_q   <= s1_idx_q;
    end
  end

  assign scan_busy  = (state_q != ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_value  = out_value_q;
  assign out_ch     = out_idx_q[IDX_W-1 -: CH_W];
  assign out_y      = out_idx_q[2*XY_W-1 -: XY_W];
  assign out_x      = out_idx_q[XY_W-1:0];
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: doc/polarity_time_surface.md
Name: polarity_time_surface

Overview:
- Multi-channel successor to the single-surface gradient mapping stage: one timestamp plane per event polarity/channel.
- Per-channel valid flags; runtime-selectable decay law (exponential or linear) with runtime decay shift.
- On request, a scan FSM streams the whole decayed surface frame over a valid/ready interface to the classifier feature buffer, using one time snapshot per frame.

Parameters:
- GRID_SIZE, 16, cells per axis (power of two).
- NUM_CH, 2, channels/planes (power of two; 2 = ON/OFF polarity).
- TS_BITS, 16, timestamp width.
- VALUE_BITS, 8, output value width.
- MAX_VALUE, 255, value of a freshly hit cell.
- SHIFT_BITS, 4, width of cfg_shift.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- t_now  in  TS_BITS  free-running time.
- ev_valid  in  1  event write strobe (always accepted).
- ev_ch  in  log2(NUM_CH)  event channel.
- ev_x, ev_y  in  log2(GRID_SIZE) each  event cell.
- ev_ts  in  TS_BITS  event timestamp.
- cfg_mode  in  1  0 = exponential, 1 = linear; sampled at scan start.
- cfg_shift  in  SHIFT_BITS  decay step = 2^cfg_shift ticks; sampled at scan start.
- scan_start  in  1  frame request pulse.
- scan_clear  in  1  invalidate each cell as it is read; sampled with scan_start.
- scan_busy  out  1  frame in progress.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_value  out  VALUE_BITS  decayed cell value.
- out_ch, out_x, out_y  out  channel/cell indices of beat.
- out_last  out  1  final beat of frame.
- frame_done  out  1  one-cycle pulse after last handshake.

Behaviour:
- Reset (async, active-high): every valid flag clears to 0; FSM to IDLE. scan_busy, out_valid, out_last, frame_done, out_value, out_ch, out_x, out_y all reset to 0. Timestamp RAM is not reset.
- Write path:
  - On ev_valid, addr = ch*GRID^2 + y*GRID + x.
  - ts[addr] <= ev_ts and valid[addr] <= 1 at the next edge, in every FSM state.
- FSM states:
  - IDLE: on scan_start go to RUN. Capture t_snap = t_now, mode, shift and clear in the same edge. Set scan_busy and the read index to 0.
  - RUN: issue reads in order ch, then y, then x (x fastest). After index NUM_CH*GRID^2-1 is issued, go to DRAIN.
  - DRAIN: on the handshake of the out_last beat, go to IDLE. scan_busy drops and frame_done pulses on the following cycle.
  - scan_start outside IDLE is ignored.
- Pipeline: 3 stages.
  - S0: RAM and flag read registered.
  - S1: delta = (t_snap - ts) mod 2^TS_BITS (wrap-safe); steps = delta >> shift.
  - S2: value.
    - Invalid cell: 0.
    - Exponential: MAX_VALUE >> steps, or 0 if steps >= VALUE_BITS.
    - Linear: MAX_VALUE - steps, saturating at 0.
  - First out_valid 3 cycles after the scan_start edge. Throughput is 1 beat per cycle while out_ready = 1.
- Handshake:
  - Beat transfers when out_valid && out_ready.
  - Advance enable for all stages and the read index = !out_valid || out_ready.
  - While stalled, out_* are held stable and no index is skipped or duplicated.
  - out_valid never drops without a handshake.
- Clear-on-read: when clear was captured, valid[i] <= 0 on the edge that issues read i.
- Simultaneous event and read/clear of the same cell:
  - The read returns the old timestamp and flag (read-before-write).
  - The event's write and set win over the clear, so the cell stays valid.
- Events during a scan update memory. A cell already read reports its new value only in the next frame.
- Reset mid-frame aborts immediately; no frame_done.
- Widths: all index and address arithmetic is sized to log2(NUM_CH*GRID^2); the shift uses the full steps width, never truncated.

Test Plan:
- Exp decay: mode=0, shift=6; event ch0 (3,2) ts=100; scan at t_now=292 -> beat index 35 value 255>>3 = 31. Never-written cells give 0. out_last on beat 511, frame_done one cycle later.
- Linear and wrap: mode=1, shift=2; event ts=0xFFF0; scan at t_now=0x0010 -> delta=32, steps=8, value=247. Event ts=0 with t_now=0x0800 -> steps=512 -> 0.
- Backpressure: random out_ready (~40% duty) over a full frame -> exactly 512 beats in order (ch, y, x); values match the model; outputs stable while stalled; out_ready held low 20 cycles -> no loss or duplication.
- Clear-on-read collision: scan_clear=1; ev_valid to cell (1,5,5) on the cycle it is read -> beat shows the old value; next frame shows the fresh value (MAX_VALUE at delta 0); all other cells are 0 in the second frame.
- Ignored start / t_snap: scan_start repeated mid-frame -> ignored, a single frame only; t_now advances during the frame but all beats use t_snap.
- Async reset mid-frame: rst at beat 100 -> out_valid and scan_busy drop with no clock edge; all cells read 0 in the next frame; no frame_done.
